// File: rtl/vga_timing_generator_pkg.sv
// Shared constants for the VGA raster timing generator: default 640x480@60
// timing, derived totals and sync windows, and the coordinate type.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  typedef logic [COORD_W-1:0] coord_t;

  // Half-open window test: lo <= v < hi
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_generator_if.sv
// Raster timing bundle driven by vga_timing_generator and read by renderers.
// frame_count is present only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_generator_if;
  import vga_timing_pkg::*;

  logic   pixel_en;
  coord_t current_pixel_x;
  coord_t current_pixel_y;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   frame_tick;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  modport master (
    output pixel_en, current_pixel_x, current_pixel_y, hsync, vsync, video_on, frame_tick
`ifdef VGA_FRAME_COUNT_EN
    , frame_count
`endif
  );

  modport slave (
    input pixel_en, current_pixel_x, current_pixel_y, hsync, vsync, video_on, frame_tick
`ifdef VGA_FRAME_COUNT_EN
    , frame_count
`endif
  );

endinterface

// File: rtl/vga_timing_generator_pixel_enable_divider.sv
// Divides the system clock into a registered one-cycle pixel enable that is
// high in the cycle where the divider count sits at CLK_DIV-1.
module pixel_enable_divider #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pixel_en
);

  // A single-state divider still needs a 1-bit counter to keep the code uniform
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;

  // Next divider count with exact wrap at CLK_DIV-1
  always_comb begin
    div_next = div + DIV_W'(1);
    if (div == DIV_LAST) begin
      div_next = '0;
    end
  end

  // Register the count and flag the cycle in which the new count is the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= '0;
      pixel_en <= 1'b0;
    end else begin
      div      <= div_next;
      pixel_en <= (div_next == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing generator: sweeps x/y over the full frame on each pixel
// enable and emits hsync, vsync, video_on and an end-of-visible-frame tick.
// Optional macro VGA_FRAME_COUNT_EN adds a 16-bit completed-frame counter.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vga_timing_generator_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS      = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS      = coord_t'(V_VISIBLE);
  localparam coord_t HS_START   = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END     = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_START   = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END     = coord_t'(V_VISIBLE + V_FP + V_SYNC);
  localparam coord_t TICK_X     = coord_t'(H_VISIBLE - 1);
  localparam coord_t TICK_Y     = coord_t'(V_VISIBLE - 1);

  logic   pixel_en;
  coord_t x, y;
  coord_t x_next, y_next;
  logic   hsync, vsync, video_on;
  logic   frame_wrap;

  pixel_enable_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .pixel_en (pixel_en)
  );

  // Next raster position: advance on pixel_en, wrap x then y exactly at the totals
  always_comb begin
    x_next = x;
    y_next = y;
    if (pixel_en) begin
      if (x == H_LAST) begin
        x_next = '0;
        if (y == V_LAST) begin
          y_next = '0;
        end else begin
          y_next = y + coord_t'(1);
        end
      end else begin
        x_next = x + coord_t'(1);
      end
    end
  end

  // Counters plus sync/video decode taken from the next position so they line up with x/y
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
      video_on <= 1'b1;
    end else begin
      x        <= x_next;
      y        <= y_next;
      hsync    <= in_window(x_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync    <= in_window(y_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      video_on <= (x_next < H_VIS) && (y_next < V_VIS);
    end
  end

  // Edge on which (H_TOTAL-1, V_TOTAL-1) rolls over to (0, 0)
  assign frame_wrap = pixel_en && (x == H_LAST) && (y == V_LAST);

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count;

  // Count completed frames on the full-frame wrap, modulo 2^16
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
    end else if (frame_wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end

  assign vga.frame_count = frame_count;
`else
  logic unused_frame_wrap;
  assign unused_frame_wrap = frame_wrap;
`endif

  assign vga.pixel_en        = pixel_en;
  assign vga.current_pixel_x = x;
  assign vga.current_pixel_y = y;
  assign vga.hsync           = hsync;
  assign vga.vsync           = vsync;
  assign vga.video_on        = video_on;
  // Restricting the tick to the enable cycle keeps it one clk wide for any CLK_DIV
  assign vga.frame_tick      = pixel_en && (x == TICK_X) && (y == TICK_Y);

endmodule
